// File: rtl/hsx_to_rgb_pipe.sv
// Pipelined HSL/HSV to RGB converter with valid/ready handshake, saturating channel sums
// and an opaque sideband tag that travels with each sample through the three stages.
module hsx_to_rgb_pipe #(
  parameter int HUE_DEPTH = 8,
  parameter int SAT_DEPTH = 8,
  parameter int RGB_DEPTH = 8,
  parameter int TAG_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [HUE_DEPTH-1:0] in_h,
  input  logic [SAT_DEPTH-1:0] in_s,
  input  logic [RGB_DEPTH-1:0] in_lv,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RGB_DEPTH-1:0] out_r,
  output logic [RGB_DEPTH-1:0] out_g,
  output logic [RGB_DEPTH-1:0] out_b,
  output logic [TAG_WIDTH-1:0] out_tag
);
  localparam int H      = HUE_DEPTH;
  localparam int S      = SAT_DEPTH;
  localparam int R      = RGB_DEPTH;
  localparam int PW_HSL = R + S + 1;
  localparam int PW_HSV = R + S;
  localparam int PW_X   = R + H + 1;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- stage 1: chroma, hue*6, operands for m ----------------
  logic [R:0]        l2;
  logic [PW_HSL-1:0] l2_ext;
  logic [PW_HSV-1:0] lv_ext;
  logic [R-1:0]      c_hsl;
  logic [R-1:0]      c_hsv;
  logic [R-1:0]      c_in;
  logic [R-1:0]      msub_in;
  logic [H+2:0]      h6_in;

  always_comb begin
    // Upper half of lightness folds back: 2^(R+1) - 2*lv, which is a plain negate mod 2^(R+1)
    l2      = in_lv[R-1] ? ({(R+1){1'b0}} - {in_lv, 1'b0}) : {in_lv, 1'b0};
    l2_ext  = PW_HSL'(l2);
    lv_ext  = PW_HSV'(in_lv);
    c_hsl   = R'((l2_ext * PW_HSL'(in_s)) >> S);
    c_hsv   = R'((lv_ext * PW_HSV'(in_s)) >> S);
    c_in    = in_mode ? c_hsv : c_hsl;
    msub_in = in_mode ? c_hsv : (c_hsl >> 1);
    h6_in   = (H+3)'(in_h) * (H+3)'(6);
  end

  logic                 s1_valid_reg;
  logic [R-1:0]         s1_c_reg;
  logic [R-1:0]         s1_msub_reg;
  logic [R-1:0]         s1_lv_reg;
  logic [H+2:0]         s1_h6_reg;
  logic [TAG_WIDTH-1:0] s1_tag_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_c_reg     <= '0;
      s1_msub_reg  <= '0;
      s1_lv_reg    <= '0;
      s1_h6_reg    <= '0;
      s1_tag_reg   <= '0;
    end else if (adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_c_reg    <= c_in;
        s1_msub_reg <= msub_in;
        s1_lv_reg   <= in_lv;
        s1_h6_reg   <= h6_in;
        s1_tag_reg  <= in_tag;
      end
    end
  end

  // ---------------- stage 2: secondary component x, offset m ----------------
  logic [H:0]      f;
  logic [H:0]      xf;
  logic [PW_X-1:0] c_ext;
  logic [R-1:0]    x_s2;
  logic [R-1:0]    m_s2;

  always_comb begin
    f     = s1_h6_reg[H:0];
    xf    = f[H] ? ({(H+1){1'b0}} - f) : f;
    c_ext = PW_X'(s1_c_reg);
    x_s2  = R'((c_ext * PW_X'(xf)) >> H);
    m_s2  = s1_lv_reg - s1_msub_reg;
  end

  logic                 s2_valid_reg;
  logic [R-1:0]         s2_c_reg;
  logic [R-1:0]         s2_x_reg;
  logic [R-1:0]         s2_m_reg;
  logic [2:0]           s2_sector_reg;
  logic [TAG_WIDTH-1:0] s2_tag_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg  <= 1'b0;
      s2_c_reg      <= '0;
      s2_x_reg      <= '0;
      s2_m_reg      <= '0;
      s2_sector_reg <= '0;
      s2_tag_reg    <= '0;
    end else if (adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_c_reg      <= s1_c_reg;
        s2_x_reg      <= x_s2;
        s2_m_reg      <= m_s2;
        s2_sector_reg <= s1_h6_reg[H+2:H];
        s2_tag_reg    <= s1_tag_reg;
      end
    end
  end

  // ---------------- stage 3: sector routing and saturating add ----------------
  logic [R-1:0] ch_pre [3];
  logic [R-1:0] ch_sat [3];

  always_comb begin
    ch_pre[0] = '0;
    ch_pre[1] = '0;
    ch_pre[2] = '0;
    case (s2_sector_reg)
      3'd0: begin ch_pre[0] = s2_c_reg; ch_pre[1] = s2_x_reg; end
      3'd1: begin ch_pre[0] = s2_x_reg; ch_pre[1] = s2_c_reg; end
      3'd2: begin ch_pre[1] = s2_c_reg; ch_pre[2] = s2_x_reg; end
      3'd3: begin ch_pre[1] = s2_x_reg; ch_pre[2] = s2_c_reg; end
      3'd4: begin ch_pre[0] = s2_x_reg; ch_pre[2] = s2_c_reg; end
      3'd5: begin ch_pre[0] = s2_c_reg; ch_pre[2] = s2_x_reg; end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sat
      logic [R:0] sum;
      assign sum        = {1'b0, ch_pre[gi]} + {1'b0, s2_m_reg};
      assign ch_sat[gi] = sum[R] ? {R{1'b1}} : sum[R-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= s2_valid_reg;
      if (s2_valid_reg) begin
        out_r   <= ch_sat[0];
        out_g   <= ch_sat[1];
        out_b   <= ch_sat[2];
        out_tag <= s2_tag_reg;
      end
    end
  end

endmodule

// File: tb/tb_hsx_to_rgb_pipe.sv
// Directed bench for hsx_to_rgb_pipe: hand-computed vectors, stall/order stream,
// full hue sweep against an integer reference, and mid-stream reset.
module tb_hsx_to_rgb_pipe;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_mode = 1'b0;
  logic [7:0]    in_h = '0;
  logic [7:0]    in_s = '0;
  logic [7:0]    in_lv = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    out_r;
  logic [7:0]    out_g;
  logic [7:0]    out_b;
  logic [TW-1:0] out_tag;

  hsx_to_rgb_pipe #(
    .HUE_DEPTH(8), .SAT_DEPTH(8), .RGB_DEPTH(8), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_h(in_h), .in_s(in_s), .in_lv(in_lv), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    r;
    logic [7:0]    g;
    logic [7:0]    b;
    logic [TW-1:0] tag;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   received = 0;
  exp_t exp_q[$];
  logic hold_pending = 1'b0;
  exp_t hold_val;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic mode, input logic [7:0] h, input logic [7:0] s,
                                 input logic [7:0] lv, input logic [TW-1:0] tag);
    int hi, si, li, l2, c, m, h6, sector, f, xf, x;
    int ch[3];
    exp_t e;
    hi = int'(h); si = int'(s); li = int'(lv);
    if (mode) begin
      c = (li * si) / 256;
      m = li - c;
    end else begin
      l2 = (li >= 128) ? 512 - 2 * li : 2 * li;
      c  = (l2 * si) / 256;
      m  = li - c / 2;
    end
    h6     = hi * 6;
    sector = h6 / 256;
    f      = h6 % 512;
    xf     = (f >= 256) ? 512 - f : f;
    x      = (c * xf) / 256;
    case (sector)
      0: ch = '{c, x, 0};
      1: ch = '{x, c, 0};
      2: ch = '{0, c, x};
      3: ch = '{0, x, c};
      4: ch = '{x, 0, c};
      5: ch = '{c, 0, x};
      default: ch = '{0, 0, 0};
    endcase
    for (int i = 0; i < 3; i++) begin
      ch[i] = ch[i] + m;
      if (ch[i] > 255) ch[i] = 255;
    end
    e.r = 8'(ch[0]); e.g = 8'(ch[1]); e.b = 8'(ch[2]); e.tag = tag;
    return e;
  endfunction

  // One clock of streaming: inputs already driven at the falling edge.
  task automatic step();
    exp_t e;
    #1;
    chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
    if (hold_pending) begin
      chk("stall_valid_hold", 32'(out_valid), 32'(1));
      chk("stall_data_hold", 32'({out_r, out_g, out_b, out_tag}), 32'(hold_val));
    end
    hold_pending = out_valid && !out_ready;
    hold_val     = {out_r, out_g, out_b, out_tag};
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        $display("out tag=%0h rgb=%0d/%0d/%0d", out_tag, out_r, out_g, out_b);
        chk("stream_rgb_tag", 32'({out_r, out_g, out_b, out_tag}), 32'(e));
        received++;
      end
    end
    if (in_valid && in_ready) exp_q.push_back(model(in_mode, in_h, in_s, in_lv, in_tag));
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single sample into an empty pipe; checks exact 3-cycle latency and the result.
  task automatic direct(input string name, input logic mode, input logic [7:0] h, input logic [7:0] s,
                        input logic [7:0] lv, input logic [TW-1:0] tag,
                        input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    out_ready = 1'b1;
    in_valid = 1'b1; in_mode = mode; in_h = h; in_s = s; in_lv = lv; in_tag = tag;
    #1;
    chk({name, "_in_ready"}, 32'(in_ready), 32'(1));
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk({name, "_lat1"}, 32'(out_valid), 32'(0));
    @(posedge clk); @(negedge clk); #1;
    chk({name, "_lat2"}, 32'(out_valid), 32'(0));
    @(posedge clk); @(negedge clk); #1;
    chk({name, "_lat3_valid"}, 32'(out_valid), 32'(1));
    chk({name, "_rgb"}, 32'({out_r, out_g, out_b}), 32'({er, eg, eb}));
    chk({name, "_tag"}, 32'(out_tag), 32'(tag));
    $display("direct %s tag=%0h rgb=%0d/%0d/%0d", name, out_tag, out_r, out_g, out_b);
    @(posedge clk); @(negedge clk); #1;
    chk({name, "_drained"}, 32'(out_valid), 32'(0));
  endtask

  logic [7:0] h_tbl  [6] = '{8'd0, 8'd43, 8'd85, 8'd128, 8'd170, 8'd213};
  logic [7:0] lv_tbl [6] = '{8'd100, 8'd200, 8'd127, 8'd255, 8'd60, 8'd180};
  logic       rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int sent;
    int k;
    logic accepted;

    // Power-up reset, with a sample presented that must not be taken
    in_valid = 1'b1; in_h = 8'd10; in_s = 8'd255; in_lv = 8'd127; in_tag = 4'h7;
    #1 rst = 1'b1;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_rgb", 32'({out_r, out_g, out_b}), 32'(0));
    chk("reset_tag", 32'(out_tag), 32'(0));
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("reset_no_leak", 32'(received), 32'(0));

    // Hand-computed vectors
    direct("hsl_red", 1'b0, 8'd0, 8'd255, 8'd127, 4'hA, 8'd254, 8'd1, 8'd1);
    direct("hsv_cyan", 1'b1, 8'd128, 8'd255, 8'd255, 4'h5, 8'd1, 8'd255, 8'd255);
    direct("hsl_sat", 1'b0, 8'd0, 8'd255, 8'd255, 4'hC, 8'd255, 8'd255, 8'd255);

    // Mixed-mode stream with stalls
    received = 0; hold_pending = 1'b0; sent = 0; k = 0;
    while ((sent < 6 || exp_q.size() > 0 || out_valid) && k < 100) begin
      out_ready = rdy_pat[k % 4];
      if (sent < 6) begin
        in_valid = 1'b1; in_mode = sent[0]; in_h = h_tbl[sent]; in_s = 8'd200;
        in_lv = lv_tbl[sent]; in_tag = 4'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #0;
      accepted = in_valid && in_ready;
      step();
      if (accepted) sent++;
      k++;
    end
    chk("stream_count", 32'(received), 32'(6));
    chk("stream_sent", 32'(sent), 32'(6));

    // Hue sweep, both modes, two lightness/value levels
    received = 0; hold_pending = 1'b0; out_ready = 1'b1;
    for (int md = 0; md < 2; md++) begin
      for (int li = 0; li < 2; li++) begin
        for (int h = 0; h < 256; h++) begin
          in_valid = 1'b1; in_mode = md[0]; in_h = 8'(h); in_s = 8'd255;
          in_lv = (li == 1) ? 8'd255 : 8'd127; in_tag = 4'(h);
          step();
        end
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    chk("sweep_count", 32'(received), 32'(1024));

    // Reset with three samples in flight
    received = 0; hold_pending = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_mode = 1'b1; in_h = 8'(40 * i); in_s = 8'd255; in_lv = 8'd200;
      in_tag = 4'(i + 8);
      step();
    end
    chk("flight_valid_before_rst", 32'(out_valid), 32'(1));
    in_valid = 1'b1; in_h = 8'd99; in_tag = 4'hF;
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_rgb", 32'({out_r, out_g, out_b}), 32'(0));
    chk("midrst_tag", 32'(out_tag), 32'(0));
    exp_q.delete();
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    received = 0; hold_pending = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_quiet", 32'(out_valid), 32'(0));
    end
    chk("post_rst_none", 32'(received), 32'(0));
    direct("after_rst", 1'b1, 8'd128, 8'd255, 8'd255, 4'h3, 8'd1, 8'd255, 8'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
